// File: rtl/blob_pkg.sv
// Shared widths and FSM encoding for the blob locator and its divider.
package blob_pkg;
    localparam int XW = 10;   // x coordinate / centroid / box width
    localparam int YW = 9;    // y coordinate / centroid / box width
    localparam int CW = 17;   // skin pixel count width
    localparam int SW = 25;   // coordinate sum width

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DIV_X = 2'd1,
        ST_DIV_Y = 2'd2,
        ST_PUB   = 2'd3
    } blobState_t;
endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, SW steps per divide.
// Handshake: iStart is taken while idle (oBusy low); the first step happens on
// the start edge itself. oDone is high in the cycle whose closing edge performs
// the last step, and oQuotient carries the final quotient during that cycle.
module seq_divider
    import blob_pkg::*;
(
    input  logic          iCLK,
    input  logic          iRST_N,
    input  logic          iStart,
    input  logic [SW-1:0] iDividend,
    input  logic [CW-1:0] iDivisor,
    output logic          oBusy,
    output logic          oDone,
    output logic [SW-1:0] oQuotient
);
    logic [CW-1:0] remReg;
    logic [CW-1:0] dvsReg;
    logic [SW-1:0] quoReg;
    logic [4:0]    cntReg;
    logic          busyReg;

    logic          step;
    logic          last;
    logic          ge;
    logic [CW-1:0] curRem;
    logic [CW-1:0] curDvs;
    logic [CW-1:0] newRem;
    logic [SW-1:0] curQuo;
    logic [SW-1:0] newQuo;
    logic [4:0]    curCnt;
    logic [CW:0]   shifted;

    // One restoring step; a start feeds fresh operands straight into the step.
    always_comb begin
        step    = iStart | busyReg;
        curRem  = iStart ? '0 : remReg;
        curQuo  = iStart ? iDividend : quoReg;
        curDvs  = iStart ? iDivisor : dvsReg;
        curCnt  = iStart ? '0 : cntReg;
        shifted = {curRem, curQuo[SW-1]};
        ge      = (shifted >= {1'b0, curDvs});
        newRem  = ge ? CW'(shifted - {1'b0, curDvs}) : CW'(shifted);
        newQuo  = {curQuo[SW-2:0], ge};
        last    = (curCnt == 5'(SW - 1));
    end

    assign oBusy     = busyReg;
    assign oDone     = step & last;
    assign oQuotient = newQuo;

    // Iteration registers advance on every step; busy drops after the last one.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            remReg  <= '0;
            dvsReg  <= '0;
            quoReg  <= '0;
            cntReg  <= '0;
            busyReg <= 1'b0;
        end else if (step) begin
            remReg  <= newRem;
            dvsReg  <= curDvs;
            quoReg  <= newQuo;
            cntReg  <= curCnt + 5'd1;
            busyReg <= ~last;
        end
    end
endmodule

// File: rtl/binary_blob_locator.sv
// Reduces each binary skin mask frame to count, bounding box and centroid.
// Accumulation of the next frame overlaps the centroid division of the last
// one through a snapshot register set; a frame ending while the divider is
// still working is dropped and flagged with oOVERRUN.
module binary_blob_locator
    import blob_pkg::*;
#(
    parameter int IMG_W     = 320,
    parameter int IMG_H     = 240,
    parameter int MIN_COUNT = 256
)(
    input  logic          iCLK,
    input  logic          iRST_N,
    input  logic          iBinary,
    input  logic          iDVAL,
    input  logic          iFrame_En,
    output logic [CW-1:0] oCOUNT,
    output logic [XW-1:0] oCX,
    output logic [YW-1:0] oCY,
    output logic [XW-1:0] oMINX,
    output logic [XW-1:0] oMAXX,
    output logic [YW-1:0] oMINY,
    output logic [YW-1:0] oMAXY,
    output logic          oFOUND,
    output logic          oRDY,
    output logic          oOVERRUN
);
    logic [XW-1:0] xPos;
    logic [YW-1:0] yPos;
    logic [CW-1:0] accCount, nCount, snapCount;
    logic [SW-1:0] accSumX, nSumX, snapSumX;
    logic [SW-1:0] accSumY, nSumY, snapSumY;
    logic [XW-1:0] accMinX, nMinX, snapMinX;
    logic [XW-1:0] accMaxX, nMaxX, snapMaxX;
    logic [YW-1:0] accMinY, nMinY, snapMinY;
    logic [YW-1:0] accMaxY, nMaxY, snapMaxY;
    logic [XW-1:0] cxReg;
    logic [YW-1:0] cyReg;

    logic accept, skin, lastX, lastY, frameEnd;
    blobState_t state, nextState;
    logic          divStart, divBusy, divDone;
    logic [SW-1:0] dividend, divQuo;

    assign accept   = iDVAL & iFrame_En;
    assign skin     = accept & iBinary;
    assign lastX    = (xPos == XW'(IMG_W - 1));
    assign lastY    = (yPos == YW'(IMG_H - 1));
    assign frameEnd = accept & lastX & lastY;

    // Accumulator values including the pixel offered this cycle.
    always_comb begin
        nCount = accCount + CW'(skin);
        nSumX  = accSumX + (skin ? SW'(xPos) : '0);
        nSumY  = accSumY + (skin ? SW'(yPos) : '0);
        nMinX  = (skin && xPos < accMinX) ? xPos : accMinX;
        nMaxX  = (skin && xPos > accMaxX) ? xPos : accMaxX;
        nMinY  = (skin && yPos < accMinY) ? yPos : accMinY;
        nMaxY  = (skin && yPos > accMaxY) ? yPos : accMaxY;
    end

    // Raster coordinates advance on valid pixels; disabling parks them at origin.
    always_ff @(posedge iCLK) begin
        if (!iRST_N || !iFrame_En) begin
            xPos <= '0;
            yPos <= '0;
        end else if (iDVAL) begin
            if (lastX) begin
                xPos <= '0;
                yPos <= lastY ? '0 : yPos + YW'(1);
            end else begin
                xPos <= xPos + XW'(1);
            end
        end
    end

    // Running frame statistics, restarted at frame end or while disabled.
    always_ff @(posedge iCLK) begin
        if (!iRST_N || !iFrame_En || frameEnd) begin
            accCount <= '0;
            accSumX  <= '0;
            accSumY  <= '0;
            accMinX  <= '1;
            accMaxX  <= '0;
            accMinY  <= '1;
            accMaxY  <= '0;
        end else if (accept) begin
            accCount <= nCount;
            accSumX  <= nSumX;
            accSumY  <= nSumY;
            accMinX  <= nMinX;
            accMaxX  <= nMaxX;
            accMinY  <= nMinY;
            accMaxY  <= nMaxY;
        end
    end

    // Snapshot taken only when the result path is free to work on it.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            snapCount <= '0;
            snapSumX  <= '0;
            snapSumY  <= '0;
            snapMinX  <= '0;
            snapMaxX  <= '0;
            snapMinY  <= '0;
            snapMaxY  <= '0;
        end else if (frameEnd && state == ST_IDLE) begin
            snapCount <= nCount;
            snapSumX  <= nSumX;
            snapSumY  <= nSumY;
            snapMinX  <= nMinX;
            snapMaxX  <= nMaxX;
            snapMinY  <= nMinY;
            snapMaxY  <= nMaxY;
        end
    end

    // FSM state register.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) state <= ST_IDLE;
        else         state <= nextState;
    end

    // Next state and divider control: x quotient first, then y with the same unit.
    always_comb begin
        nextState = state;
        divStart  = 1'b0;
        dividend  = snapSumX;
        case (state)
            ST_IDLE: begin
                if (frameEnd) nextState = (nCount != '0) ? ST_DIV_X : ST_PUB;
            end
            ST_DIV_X: begin
                divStart = ~divBusy;
                if (divDone) nextState = ST_DIV_Y;
            end
            ST_DIV_Y: begin
                dividend = snapSumY;
                divStart = ~divBusy;
                if (divDone) nextState = ST_PUB;
            end
            ST_PUB: nextState = ST_IDLE;
            default: nextState = ST_IDLE;
        endcase
    end

    seq_divider uDiv (
        .iCLK      (iCLK),
        .iRST_N    (iRST_N),
        .iStart    (divStart),
        .iDividend (dividend),
        .iDivisor  (snapCount),
        .oBusy     (divBusy),
        .oDone     (divDone),
        .oQuotient (divQuo)
    );

    // Capture quotients as they complete, publish the result set, pulse flags.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            cxReg    <= '0;
            cyReg    <= '0;
            oCOUNT   <= '0;
            oCX      <= '0;
            oCY      <= '0;
            oMINX    <= '0;
            oMAXX    <= '0;
            oMINY    <= '0;
            oMAXY    <= '0;
            oFOUND   <= 1'b0;
            oRDY     <= 1'b0;
            oOVERRUN <= 1'b0;
        end else begin
            oRDY     <= (state == ST_PUB);
            oOVERRUN <= frameEnd && (state != ST_IDLE);
            if (state == ST_DIV_X && divDone) cxReg <= XW'(divQuo);
            if (state == ST_DIV_Y && divDone) cyReg <= YW'(divQuo);
            if (state == ST_PUB) begin
                oCOUNT <= snapCount;
                if (snapCount == '0) begin
                    oCX    <= '0;
                    oCY    <= '0;
                    oMINX  <= '0;
                    oMAXX  <= '0;
                    oMINY  <= '0;
                    oMAXY  <= '0;
                    oFOUND <= 1'b0;
                end else begin
                    oCX    <= cxReg;
                    oCY    <= cyReg;
                    oMINX  <= snapMinX;
                    oMAXX  <= snapMaxX;
                    oMINY  <= snapMinY;
                    oMAXY  <= snapMaxY;
                    oFOUND <= (snapCount >= CW'(MIN_COUNT));
                end
            end
        end
    end
endmodule

// File: tb/tb_binary_blob_locator.sv
// Directed bench: a 128x64 instance for the frame-level cases and a 4x2
// instance for back-to-back short frames that collide with the divider.
module tb_binary_blob_locator;
    localparam int MW = 128;
    localparam int MH = 64;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rstN;
    always #5 clk = ~clk;

    // ---------------- main instance ----------------
    logic        mBin, mDval, mEn;
    logic [16:0] mCount;
    logic [9:0]  mCx, mMinX, mMaxX;
    logic [8:0]  mCy, mMinY, mMaxY;
    logic        mFound, mRdy, mOvr;

    binary_blob_locator #(.IMG_W(MW), .IMG_H(MH), .MIN_COUNT(256)) dut (
        .iCLK(clk), .iRST_N(rstN), .iBinary(mBin), .iDVAL(mDval), .iFrame_En(mEn),
        .oCOUNT(mCount), .oCX(mCx), .oCY(mCy), .oMINX(mMinX), .oMAXX(mMaxX),
        .oMINY(mMinY), .oMAXY(mMaxY), .oFOUND(mFound), .oRDY(mRdy), .oOVERRUN(mOvr)
    );

    // ---------------- short-frame instance ----------------
    logic        sBin, sDval, sEn;
    logic [16:0] sCount;
    logic [9:0]  sCx, sMinX, sMaxX;
    logic [8:0]  sCy, sMinY, sMaxY;
    logic        sFound, sRdy, sOvr;

    binary_blob_locator #(.IMG_W(4), .IMG_H(2), .MIN_COUNT(256)) dutShort (
        .iCLK(clk), .iRST_N(rstN), .iBinary(sBin), .iDVAL(sDval), .iFrame_En(sEn),
        .oCOUNT(sCount), .oCX(sCx), .oCY(sCy), .oMINX(sMinX), .oMAXX(sMaxX),
        .oMINY(sMinY), .oMAXY(sMaxY), .oFOUND(sFound), .oRDY(sRdy), .oOVERRUN(sOvr)
    );

    // ---------------- checking ----------------
    int nChecks = 0;
    int nFails  = 0;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    // {count17, cx10, cy9, minx10, maxx10, miny9, maxy9, found1}
    logic [74:0] expQ[$];

    function automatic logic [74:0] expWord(input int c, input int cx, input int cy,
                                            input int mnx, input int mxx,
                                            input int mny, input int mxy, input int f);
        return {17'(c), 10'(cx), 9'(cy), 10'(mnx), 10'(mxx), 9'(mny), 9'(mxy), 1'(f)};
    endfunction

    logic prevRdy  = 1'b0;
    int   mOvrCnt  = 0;
    int   sOvrCnt  = 0;
    int   sRdyCnt  = 0;

    // Compare every main publish against the oldest expected result.
    always @(negedge clk) begin
        if (mRdy) begin
            checkVal("rdy_single_cycle", prevRdy, 0);
            if (expQ.size() == 0) begin
                checkVal("rdy_unexpected", 1, 0);
            end else begin
                checkVal("count", mCount, expQ[0][74:58]);
                checkVal("cx",    mCx,    expQ[0][57:48]);
                checkVal("cy",    mCy,    expQ[0][47:39]);
                checkVal("minx",  mMinX,  expQ[0][38:29]);
                checkVal("maxx",  mMaxX,  expQ[0][28:19]);
                checkVal("miny",  mMinY,  expQ[0][18:10]);
                checkVal("maxy",  mMaxY,  expQ[0][9:1]);
                checkVal("found", mFound, expQ[0][0]);
                void'(expQ.pop_front());
            end
        end
        prevRdy <= mRdy;
        if (mOvr) mOvrCnt <= mOvrCnt + 1;
        if (sOvr) sOvrCnt <= sOvrCnt + 1;
        if (sRdy) sRdyCnt <= sRdyCnt + 1;
    end

    // ---------------- driver tasks ----------------
    task automatic waitRdy(input int expLat, input string tag);
        int lat = 0;
        while (lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (mRdy) break;
        end
        checkVal(tag, lat, expLat);
    endtask

    // One full main frame; skin inside [x0..x1]x[y0..y1], optional iDVAL gap
    // before every gap-th pixel, then the publish latency is checked.
    task automatic driveRect(input int x0, input int x1, input int y0, input int y1,
                             input int gap, input int expLat, input string tag);
        int idx = 0;
        for (int y = 0; y < MH; y++) begin
            for (int x = 0; x < MW; x++) begin
                if (gap > 0 && (idx % gap) == gap - 1) begin
                    mDval = 1'b0;
                    mBin  = 1'b1;
                    @(posedge clk); #1;
                end
                mDval = 1'b1;
                mBin  = (x >= x0 && x <= x1 && y >= y0 && y <= y1);
                @(posedge clk); #1;
                idx++;
            end
        end
        mDval = 1'b0;
        mBin  = 1'b0;
        waitRdy(expLat, tag);
    endtask

    task automatic driveSkinPixels(input int n);
        for (int i = 0; i < n; i++) begin
            mDval = 1'b1;
            mBin  = 1'b1;
            @(posedge clk); #1;
        end
        mDval = 1'b0;
        mBin  = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic [15:0] sPat;
    int          sLat;

    initial begin
        rstN  = 1'b0;
        mBin  = 1'b0; mDval = 1'b0; mEn = 1'b1;
        sBin  = 1'b0; sDval = 1'b0; sEn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkVal("reset_count", mCount, 0);
        checkVal("reset_cx",    mCx,    0);
        checkVal("reset_maxx",  mMaxX,  0);
        checkVal("reset_rdy",   mRdy,   0);
        checkVal("reset_ovr",   mOvr,   0);
        checkVal("reset_found", mFound, 0);
        rstN = 1'b1;

        // 4x4 square: count 16, centroid (101,51)
        expQ.push_back(expWord(16, 101, 51, 100, 103, 50, 53, 0));
        driveRect(100, 103, 50, 53, 0, 51, "lat_square");

        // Reset for 3 cycles mid-frame clears the published outputs
        driveSkinPixels(4000);
        rstN  = 1'b0;
        mDval = 1'b1;
        mBin  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkVal("midreset_count", mCount, 0);
        checkVal("midreset_cx",    mCx,    0);
        checkVal("midreset_cy",    mCy,    0);
        checkVal("midreset_minx",  mMinX,  0);
        checkVal("midreset_maxx",  mMaxX,  0);
        checkVal("midreset_miny",  mMinY,  0);
        checkVal("midreset_maxy",  mMaxY,  0);
        checkVal("midreset_rdy",   mRdy,   0);
        rstN = 1'b1;

        // All-skin frame right after reset: 8192 pixels, centroid (63,31)
        expQ.push_back(expWord(8192, 63, 31, 0, 127, 0, 63, 1));
        driveRect(0, MW - 1, 0, MH - 1, 0, 51, "lat_full_skin");

        // All-background frame publishes one cycle after the last pixel
        expQ.push_back(expWord(0, 0, 0, 0, 0, 0, 0, 0));
        driveRect(1, 0, 0, 0, 0, 1, "lat_background");

        // Enable dropped mid-frame, then a full frame with iDVAL gaps
        driveSkinPixels(3000);
        mEn   = 1'b0;
        mDval = 1'b1;
        mBin  = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        mEn = 1'b1;
        expQ.push_back(expWord(20, 14, 5, 10, 19, 5, 6, 0));
        driveRect(10, 19, 5, 6, 16, 51, "lat_rect_gaps");

        // Exactly MIN_COUNT skin pixels sets oFOUND
        expQ.push_back(expWord(256, 7, 7, 0, 15, 0, 15, 1));
        driveRect(0, 15, 0, 15, 0, 51, "lat_min_count");

        // Two 4x2 frames back to back: second ends during DIV_X and is dropped
        sPat = 16'b1111_1111_1000_1111;
        for (int i = 0; i < 16; i++) begin
            sDval = 1'b1;
            sBin  = sPat[i];
            @(posedge clk); #1;
        end
        sDval = 1'b0;
        sBin  = 1'b0;
        checkVal("short_ovr_at_drop", sOvr, 1);
        sLat = 0;
        while (sLat < 200) begin
            @(posedge clk); #1;
            sLat++;
            if (sRdy) break;
        end
        checkVal("short_rdy_lat", sLat, 43);
        checkVal("short_count", sCount, 5);
        checkVal("short_cx",    sCx,    1);
        checkVal("short_cy",    sCy,    0);
        checkVal("short_minx",  sMinX,  0);
        checkVal("short_maxx",  sMaxX,  3);
        checkVal("short_miny",  sMinY,  0);
        checkVal("short_maxy",  sMaxY,  1);
        checkVal("short_found", sFound, 0);
        repeat (100) @(posedge clk);
        #1;
        checkVal("short_rdy_pulses", sRdyCnt, 1);
        checkVal("short_ovr_pulses", sOvrCnt, 1);

        checkVal("main_ovr_pulses", mOvrCnt, 0);
        checkVal("scoreboard_drained", expQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
